// File: rtl/mmr_intr_coalesce.sv
// N-bank interrupt status/mask register block with write-1-to-clear status and
// per-bank interrupt coalescing on an event-count threshold or a timeout.
module mmr_intr_coalesce #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8,
  parameter int TMR_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N-1:0][WIDTH-1:0] isr_pulses,
  input  logic                    wr_en,
  input  logic [$clog2(N)+1:0]    wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  input  logic [$clog2(N)+1:0]    rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic [N-1:0][WIDTH-1:0] imr,
  output logic [N-1:0][WIDTH-1:0] isr,
  output logic [N-1:0]            interrupts
);
  localparam int BW = $clog2(N);
  localparam int AW = BW + 2;
  localparam int NP = 1 << BW;

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

  logic [BW-1:0]         w_wr_bank;
  logic [BW-1:0]         w_rd_bank;
  logic [1:0]            w_wr_reg;
  logic [1:0]            w_rd_reg;
  logic [3:0][WIDTH-1:0] w_regs [NP];
  logic [WIDTH-1:0]      r_rd_data;

  assign w_wr_bank = wr_addr[AW-1:2];
  assign w_wr_reg  = wr_addr[1:0];
  assign w_rd_bank = rd_addr[AW-1:2];
  assign w_rd_reg  = rd_addr[1:0];

  for (genvar g = 0; g < N; g++) begin : g_bank
    state_t               r_state;
    logic [WIDTH-1:0]     r_isr;
    logic [WIDTH-1:0]     r_imr;
    logic [CNT_WIDTH-1:0] r_thr;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [TMR_WIDTH-1:0] r_tmo;
    logic [TMR_WIDTH-1:0] r_tmr;
    logic                 r_intr;
    logic                 w_sel;
    logic [WIDTH-1:0]     w_w1c;
    logic [WIDTH-1:0]     w_isr_next;
    logic [WIDTH-1:0]     w_imr_next;
    logic                 w_pending;
    logic                 w_event;
    logic                 w_fire;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [TMR_WIDTH-1:0] w_tmr_next;

    assign w_sel      = wr_en && (w_wr_bank == BW'(g));
    assign w_w1c      = (w_sel && w_wr_reg == 2'd0) ? wr_data : '0;
    assign w_imr_next = (w_sel && w_wr_reg == 2'd1) ? wr_data : r_imr;
    assign w_isr_next = (r_isr & ~w_w1c) | isr_pulses[g];
    assign w_pending  = |(w_isr_next & w_imr_next);
    assign w_event    = |(isr_pulses[g] & w_imr_next);

    // Both counters stick at all-ones instead of wrapping
    assign w_cnt_next = (w_event && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    assign w_tmr_next = (&r_tmr) ? r_tmr : r_tmr + 1'b1;
    assign w_fire     = (w_cnt_next >= r_thr) ||
                        ((r_tmo != '0) && (w_tmr_next >= r_tmo));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_state <= IDLE;
        r_isr   <= '0;
        r_imr   <= '0;
        r_thr   <= '0;
        r_tmo   <= '0;
        r_cnt   <= '0;
        r_tmr   <= '0;
        r_intr  <= 1'b0;
      end else begin
        r_isr <= w_isr_next;
        r_imr <= w_imr_next;
        if (w_sel && w_wr_reg == 2'd2) r_thr <= wr_data[CNT_WIDTH-1:0];
        if (w_sel && w_wr_reg == 2'd3) r_tmo <= wr_data[TMR_WIDTH-1:0];
        case (r_state)
          IDLE: begin
            if (r_thr == '0 && w_pending) begin
              r_state <= FIRE;
              r_intr  <= 1'b1;
            end else if (w_event) begin
              r_cnt <= CNT_WIDTH'(1);
              r_tmr <= '0;
              if (r_thr == CNT_WIDTH'(1)) begin
                r_state <= FIRE;
                r_intr  <= 1'b1;
              end else begin
                r_state <= ACCUM;
              end
            end
          end
          ACCUM: begin
            // Software clearing or masking everything abandons the batch
            if (!w_pending) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_tmr   <= '0;
            end else begin
              r_cnt <= w_cnt_next;
              r_tmr <= w_tmr_next;
              if (w_fire) begin
                r_state <= FIRE;
                r_intr  <= 1'b1;
              end
            end
          end
          FIRE: begin
            if (!w_pending) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_tmr   <= '0;
              r_intr  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_intr  <= 1'b0;
          end
        endcase
      end
    end

    assign isr[g]        = r_isr;
    assign imr[g]        = r_imr;
    assign interrupts[g] = r_intr;
    assign w_regs[g]     = {WIDTH'(r_tmo), WIDTH'(r_thr), r_imr, r_isr};
  end

  // Address space rounds up to a power of two; absent banks read as zero
  for (genvar g = N; g < NP; g++) begin : g_pad
    assign w_regs[g] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= w_regs[w_rd_bank][w_rd_reg];
    end
  end

  assign rd_data = r_rd_data;
endmodule

// File: tb/tb_mmr_intr_coalesce.sv
// Bench for mmr_intr_coalesce: directed scenarios plus random traffic, all checked
// against a timestamp-based reference model of the coalescing rules.
module tb_mmr_intr_coalesce;
  localparam int N         = 4;
  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 8;
  localparam int TMR_WIDTH = 16;
  localparam int AW        = $clog2(N) + 2;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [N-1:0][WIDTH-1:0] isr_pulses = '0;
  logic                    wr_en = 1'b0;
  logic [AW-1:0]           wr_addr = '0;
  logic [WIDTH-1:0]        wr_data = '0;
  logic                    rd_en = 1'b0;
  logic [AW-1:0]           rd_addr = '0;
  logic [WIDTH-1:0]        rd_data;
  logic [N-1:0][WIDTH-1:0] imr;
  logic [N-1:0][WIDTH-1:0] isr;
  logic [N-1:0]            interrupts;

  mmr_intr_coalesce #(.N(N), .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .TMR_WIDTH(TMR_WIDTH)) dut (
    .clock(clock), .reset(reset), .isr_pulses(isr_pulses),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .imr(imr), .isr(isr), .interrupts(interrupts)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int errorCount = 0;

  // Next-cycle stimulus, staged by the helpers below
  logic [N-1:0][WIDTH-1:0] t_pulses = '0;
  logic                    t_wr_en = 1'b0;
  logic [AW-1:0]           t_wr_addr = '0;
  logic [WIDTH-1:0]        t_wr_data = '0;
  logic                    t_rd_en = 1'b0;
  logic [AW-1:0]           t_rd_addr = '0;

  // Reference model: batches are tracked by event count and the cycle stamp of
  // their first event, so elapsed time is a subtraction rather than a counter.
  logic [WIDTH-1:0] m_isr [N];
  logic [WIDTH-1:0] m_imr [N];
  int               m_thr [N];
  int               m_tmo [N];
  int               m_events [N];
  int               m_first [N];
  bit               m_acc [N];
  bit               m_fired [N];
  logic [WIDTH-1:0] m_rd;
  int               m_cyc = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] mkAddr(input int b, input int r);
    return AW'(b * 4 + r);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_isr[i] = '0; m_imr[i] = '0; m_thr[i] = 0; m_tmo[i] = 0;
      m_events[i] = 0; m_first[i] = 0; m_acc[i] = 1'b0; m_fired[i] = 1'b0;
    end
    m_rd = '0;
  endtask

  task automatic modelStep();
    int b;
    int r;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] nIsr;
    logic [WIDTH-1:0] nImr;
    bit live;
    bit hit;
    bit mine;
    if (t_rd_en) begin
      b = int'(t_rd_addr[AW-1:2]);
      r = int'(t_rd_addr[1:0]);
      case (r)
        0:       m_rd = m_isr[b];
        1:       m_rd = m_imr[b];
        2:       m_rd = WIDTH'(m_thr[b]);
        default: m_rd = WIDTH'(m_tmo[b]);
      endcase
    end
    for (int i = 0; i < N; i++) begin
      mine = t_wr_en && (int'(t_wr_addr[AW-1:2]) == i);
      r    = int'(t_wr_addr[1:0]);
      w1c  = (mine && r == 0) ? t_wr_data : '0;
      nImr = (mine && r == 1) ? t_wr_data : m_imr[i];
      nIsr = (m_isr[i] & ~w1c) | t_pulses[i];
      live = |(nIsr & nImr);
      hit  = |(t_pulses[i] & nImr);
      if (m_fired[i]) begin
        if (!live) m_fired[i] = 1'b0;
      end else if (m_acc[i]) begin
        if (!live) begin
          m_acc[i] = 1'b0;
        end else begin
          if (hit) m_events[i]++;
          if (m_events[i] >= m_thr[i] || (m_tmo[i] != 0 && m_cyc - m_first[i] >= m_tmo[i])) begin
            m_acc[i] = 1'b0;
            m_fired[i] = 1'b1;
          end
        end
      end else if (m_thr[i] == 0 && live) begin
        m_fired[i] = 1'b1;
      end else if (hit) begin
        m_events[i] = 1;
        m_first[i] = m_cyc;
        if (m_thr[i] == 1) m_fired[i] = 1'b1;
        else m_acc[i] = 1'b1;
      end
      m_isr[i] = nIsr;
      m_imr[i] = nImr;
      if (mine && r == 2) m_thr[i] = int'(t_wr_data[CNT_WIDTH-1:0]);
      if (mine && r == 3) m_tmo[i] = int'(t_wr_data[TMR_WIDTH-1:0]);
    end
    m_cyc++;
  endtask

  task automatic applyStimulus();
    logic [N-1:0] expIntr;
    isr_pulses = t_pulses;
    wr_en = t_wr_en; wr_addr = t_wr_addr; wr_data = t_wr_data;
    rd_en = t_rd_en; rd_addr = t_rd_addr;
    modelStep();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("isr[%0d]", i), 64'(isr[i]), 64'(m_isr[i]));
      expIntr[i] = m_fired[i];
    end
    checkOutput("interrupts", 64'(interrupts), 64'(expIntr));
    checkOutput("rd_data", 64'(rd_data), 64'(m_rd));
    t_pulses = '0; t_wr_en = 1'b0; t_wr_addr = '0; t_wr_data = '0;
    t_rd_en = 1'b0; t_rd_addr = '0;
    @(negedge clock);
  endtask

  task automatic doWrite(input int b, input int r, input logic [WIDTH-1:0] d);
    t_wr_en = 1'b1; t_wr_addr = mkAddr(b, r); t_wr_data = d;
    applyStimulus();
  endtask

  task automatic doRead(input int b, input int r);
    t_rd_en = 1'b1; t_rd_addr = mkAddr(b, r);
    applyStimulus();
  endtask

  task automatic doPulse(input int b, input logic [WIDTH-1:0] bits);
    t_pulses[b] = bits;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  // Called just after a falling edge; reset is pulsed between clock edges
  task automatic asyncReset();
    #2 reset = 1'b1;
    #1;
    checkOutput("async_intr", 64'(interrupts), 64'd0);
    for (int i = 0; i < N; i++) checkOutput($sformatf("async_isr[%0d]", i), 64'(isr[i]), 64'd0);
    modelReset();
    #1 reset = 1'b0;
  endtask

  initial begin
    modelReset();
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_intr", 64'(interrupts), 64'd0);
    checkOutput("rst_rd", 64'(rd_data), 64'd0);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst_isr[%0d]", i), 64'(isr[i]), 64'd0);
      checkOutput($sformatf("rst_imr[%0d]", i), 64'(imr[i]), 64'd0);
    end
    @(negedge clock);
    reset = 1'b0;

    // THR=0: immediate interrupt, W1C drops it on the same edge
    doWrite(0, 1, 32'h1);
    doPulse(0, 32'h1);
    checkOutput("thr0_isr", 64'(isr[0]), 64'h1);
    checkOutput("thr0_intr", 64'(interrupts[0]), 64'd1);
    doWrite(0, 0, 32'h1);
    checkOutput("w1c_intr", 64'(interrupts[0]), 64'd0);
    checkOutput("w1c_isr", 64'(isr[0]), 64'd0);

    // Count coalescing: four event cycles, one of them a two-bit pulse
    doWrite(1, 1, 32'hF);
    doWrite(1, 2, 32'd4);
    doPulse(1, 32'h1);
    checkOutput("cnt_ev1", 64'(interrupts[1]), 64'd0);
    idleCycles(2);
    doPulse(1, 32'h6);
    checkOutput("cnt_ev2", 64'(interrupts[1]), 64'd0);
    doPulse(1, 32'h8);
    checkOutput("cnt_ev3", 64'(interrupts[1]), 64'd0);
    idleCycles(1);
    doPulse(1, 32'h1);
    checkOutput("cnt_ev4", 64'(interrupts[1]), 64'd1);
    doWrite(1, 0, 32'hF);
    checkOutput("cnt_clr", 64'(interrupts[1]), 64'd0);

    // Timeout: fires exactly 20 edges after the first event's edge
    doWrite(2, 1, 32'h1);
    doWrite(2, 2, 32'd100);
    doWrite(2, 3, 32'd20);
    doPulse(2, 32'h1);
    checkOutput("tmo_t0", 64'(interrupts[2]), 64'd0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus();
      checkOutput($sformatf("tmo_t%0d", k), 64'(interrupts[2]), (k == 20) ? 64'd1 : 64'd0);
    end
    doWrite(2, 0, 32'h1);
    doPulse(2, 32'h1);
    idleCycles(5);
    doWrite(2, 0, 32'h1);
    idleCycles(25);
    checkOutput("tmo_abort", 64'(interrupts[2]), 64'd0);

    // Clear/pulse collision keeps the line up; masking drops it
    doPulse(0, 32'h1);
    t_pulses[0] = 32'h1;
    doWrite(0, 0, 32'h1);
    checkOutput("coll_isr", 64'(isr[0]), 64'h1);
    checkOutput("coll_intr", 64'(interrupts[0]), 64'd1);
    doWrite(0, 1, 32'h0);
    checkOutput("mask_intr", 64'(interrupts[0]), 64'd0);
    checkOutput("mask_isr", 64'(isr[0]), 64'h1);
    doWrite(0, 0, 32'h1);

    // Register file: distinct values per bank, garbage in unused THR/TMO bits
    for (int b = 0; b < N; b++) begin
      doWrite(b, 1, 32'h1000_0000 * (b + 1) + 32'h55);
      doWrite(b, 2, 32'hABCD_0000 | (32'h11 * (b + 1)));
      doWrite(b, 3, 32'h5A5A_0000 | (32'h1234 + 32'h0101 * b));
    end
    for (int b = 0; b < N; b++) begin
      doRead(b, 1);
      checkOutput($sformatf("rd_imr[%0d]", b), 64'(rd_data), 64'(32'h1000_0000 * (b + 1) + 32'h55));
      doRead(b, 2);
      checkOutput($sformatf("rd_thr[%0d]", b), 64'(rd_data), 64'(32'h11 * (b + 1)));
      doRead(b, 3);
      checkOutput($sformatf("rd_tmo[%0d]", b), 64'(rd_data), 64'(32'h1234 + 32'h0101 * b));
    end
    t_rd_en = 1'b1; t_rd_addr = mkAddr(1, 2);
    doWrite(1, 2, 32'h7E);
    checkOutput("rdwr_old", 64'(rd_data), 64'h22);
    doRead(1, 2);
    checkOutput("rdwr_new", 64'(rd_data), 64'h7E);
    doPulse(3, 32'h100);
    doRead(3, 0);
    checkOutput("rd_isr", 64'(rd_data), 64'h100);
    doRead(3, 0);
    checkOutput("rd_isr_keep", 64'(isr[3]), 64'h100);
    idleCycles(1);
    checkOutput("rd_hold", 64'(rd_data), 64'h100);

    // Async reset in the middle of a batch; afterwards a full batch is needed
    doWrite(1, 1, 32'hF);
    doWrite(1, 2, 32'd3);
    doPulse(1, 32'h1);
    doPulse(1, 32'h2);
    checkOutput("pre_rst_intr", 64'(interrupts[1]), 64'd0);
    asyncReset();
    doWrite(1, 1, 32'hF);
    doWrite(1, 2, 32'd3);
    doPulse(1, 32'h1);
    doPulse(1, 32'h2);
    checkOutput("post_rst_ev2", 64'(interrupts[1]), 64'd0);
    doPulse(1, 32'h4);
    checkOutput("post_rst_ev3", 64'(interrupts[1]), 64'd1);
    doWrite(1, 0, 32'hF);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      int b;
      int r;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0)
          t_pulses[i] = WIDTH'($urandom_range(1, 255) & $urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, N - 1);
        r = $urandom_range(0, 3);
        t_wr_en = 1'b1;
        t_wr_addr = mkAddr(b, r);
        case (r)
          0:       t_wr_data = $urandom;
          1:       t_wr_data = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(0, 255));
          2:       t_wr_data = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 5));
          default: t_wr_data = ($urandom & 32'hFFFF_0000) |
                               (($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom_range(2, 12)));
        endcase
      end
      if ($urandom_range(0, 2) == 0) begin
        t_rd_en = 1'b1;
        t_rd_addr = AW'($urandom_range(0, (1 << AW) - 1));
      end
      applyStimulus();
      if (c % 700 == 699) asyncReset();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule

// File: doc/mmr_intr_coalesce.md
# mmr_intr_coalesce

Parametrised interrupt-status block with per-bank mask, write-1-to-clear status and interrupt coalescing. It sits between event sources (one-cycle `isr_pulses`) and the memory-mapped register file, and generalises the plain `|(isr & imr)` interrupt to N banks. Each bank has a count threshold and a timeout that defer interrupt assertion until enough events have accumulated or enough time has passed.

## Interface
- `N`, 4: number of banks / interrupt lines.
- `WIDTH`, 32: status bits per bank; register data width.
- `CNT_WIDTH`, 8: width of the per-bank event threshold and counter.
- `TMR_WIDTH`, 16: width of the per-bank timeout and timer.
- `clock`  in  1: sole clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `isr_pulses`  in  [WIDTH-1:0] x N: one-cycle event pulses per bank and bit.
- `wr_en`  in  1: register write strobe.
- `wr_addr`  in  $clog2(N)+2: {bank, reg}; reg 0 = ISR (W1C), 1 = IMR, 2 = THR (low CNT_WIDTH bits), 3 = TMO (low TMR_WIDTH bits).
- `wr_data`  in  WIDTH: write data.
- `rd_en`  in  1: register read strobe.
- `rd_addr`  in  $clog2(N)+2: read address, same map.
- `rd_data`  out  WIDTH: registered read data; unused upper bits read 0.
- `imr`, `isr`  out  [WIDTH-1:0] x N: current register contents.
- `interrupts`  out  N: registered interrupt lines.

## Operation
- ISR per bank: `isr_next = (isr & ~w1c_mask) | isr_pulses`. A pulse on a bit being cleared in the same cycle wins, so the bit stays 1. Writes to IMR/THR/TMO replace the value.
- `pending = |(isr_next & imr_next)`; `event = |(isr_pulses & imr_next)`. Event counting is per cycle: a cycle counts as one event regardless of how many bits pulse.
- Per-bank FSM, states IDLE, ACCUM, FIRE; `cnt` (CNT_WIDTH, saturating) and `tmr` (TMR_WIDTH, saturating).
- IDLE:
  - If THR == 0 and pending -> FIRE.
  - Else on event: cnt = 1, tmr = 0. -> FIRE if THR == 1, else -> ACCUM.
- ACCUM:
  - tmr increments every cycle; cnt increments on event.
  - -> FIRE when cnt_next >= THR or (TMO != 0 and tmr_next >= TMO).
  - -> IDLE (cnt = tmr = 0) if !pending, i.e. software cleared or masked everything. The IDLE check has priority over the FIRE check.
  - THR/TMO changes take effect on the next comparison. Setting THR = 0 while in ACCUM -> FIRE if pending.
- FIRE: `interrupts[i] = 1`. -> IDLE with cnt = tmr = 0 when !pending. New events in FIRE do not count.
- TMO == 0 disables the timeout. Both counters saturate at all-ones and never wrap.
- Reads:
  - `rd_data` is loaded on `rd_en`; otherwise it holds its value.
  - Reading does not clear ISR.
  - A read and write to the same register in the same cycle returns the pre-write value.

## Timing
- Reset values: all isr/imr/THR/TMO = 0, cnt = tmr = 0, state IDLE, `interrupts` = 0, `rd_data` = 0.
- Pulse at edge t: `isr` bit is visible after edge t+1.
- With THR = 0 and the bit unmasked, `interrupts` asserts after the same edge (latency 1).
- With THR = k >= 1: `interrupts` asserts at the edge that registers the k-th event cycle.
- Timeout: FIRE at the edge where tmr reaches TMO. The first event's edge counts as tmr = 0.
- Deassertion: the edge that writes the W1C (or the IMR write) making pending = 0 also drops `interrupts` (same-edge deassert). A simultaneous pulse on an unmasked bit keeps it asserted.
- Read latency: 1 cycle.
- Reset asserted mid-ACCUM or mid-FIRE clears everything immediately and asynchronously. The first post-reset edge starts from IDLE.

## Test plan
- Reset and default:
  - After reset, all outputs are 0.
  - IMR[0] = 0x1, THR = 0; pulse bit 0 at cycle 10 -> `isr[0]` = 0x1 and `interrupts[0]` = 1 at cycle 11.
  - W1C 0x1 -> `interrupts[0]` = 0 after that edge.
- Count coalescing: THR[1] = 4, TMO = 0, IMR = 0xF; pulses on bits 0..3 in 4 separate cycles -> `interrupts[1]` rises only on the 4th. A 2-bit simultaneous pulse counts as 1 event.
- Timeout: THR[2] = 100, TMO = 20; single pulse at cycle t -> `interrupts[2]` rises at t+1+20. W1C at any earlier point in ACCUM returns the bank to IDLE with no interrupt.
- Clear/pulse collision: in FIRE, W1C 0x1 in the same cycle as a new pulse on bit 0 -> `isr` stays 0x1 and `interrupts` stays 1. Masking via IMR = 0 drops `interrupts` at that edge.
- Register access: write THR/TMO/IMR in all N banks with distinct values and read back with 1-cycle latency. Simultaneous read and write of the same address returns the old value. Reads do not alter ISR.
- Async reset mid-ACCUM: assert `reset` between edges -> `interrupts` and `isr` are 0 immediately. After release, the bank needs a full THR events to fire again.
